add_br_dummy_eq: RTL and testbench
==================================

ADD_BR_DUMMY_EQ -- requirements
Module: add_br_dummy_eq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, the data operand width in bits.
REQ-002 The module SHALL have parameter STATE_W, default 32, the branch-target (FSM state) width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port in0, input, WIDTH bits: adder operand A.
REQ-006 The module SHALL have port in1, input, WIDTH bits: adder operand B.
REQ-007 The module SHALL have port cmp_in1, input, WIDTH bits: comparison operand for the sum.
REQ-008 The module SHALL have port en, input, 1 bit: capture strobe for the result registers.
REQ-009 The module SHALL have port br_true_target, input, STATE_W bits: next state when the registered compare is true.
REQ-010 The module SHALL have port br_false_target, input, STATE_W bits: next state when the registered compare is false.
REQ-011 The module SHALL have port add_out, output, WIDTH bits: combinational sum.
REQ-012 The module SHALL have port eq_out, output, 1 bit: combinational (add_out == cmp_in1).
REQ-013 The module SHALL have port add_reg, output, WIDTH bits: registered sum.
REQ-014 The module SHALL have port eq_reg, output, 1 bit: registered compare.
REQ-015 The module SHALL have port br_next, output, STATE_W bits: selected branch target.

Function
REQ-016 add_out SHALL equal (in0 + in1) modulo 2^WIDTH, zero-cycle latency; overflow wraps silently.
REQ-017 eq_out SHALL be 1 iff all WIDTH bits of add_out equal cmp_in1, zero-cycle latency; the comparison is unsigned bitwise.
REQ-018 On a rising clk edge with en=1 and rst=0, add_reg SHALL load add_out and eq_reg SHALL load eq_out; latency is 1 cycle.
REQ-019 With en=0, add_reg and eq_reg SHALL hold their values indefinitely.
REQ-020 br_next SHALL be combinational: br_true_target when eq_reg=1, otherwise br_false_target; it SHALL depend only on eq_reg, never on eq_out.
REQ-021 Input changes during a cycle with en=0 SHALL affect add_out and eq_out only, never registered outputs.
REQ-022 The module SHALL contain no other state; there is no handshake beyond en.

Reset
REQ-023 While rst=1, add_reg SHALL be 0 and eq_reg SHALL be 0 immediately, independent of clk; therefore br_next=br_false_target.
REQ-024 rst SHALL override en; a reset asserted mid-operation discards any pending capture.
REQ-025 Combinational outputs add_out and eq_out SHALL remain functional during reset.

Configuration
REQ-026 With macro ADD_BR_DUMMY_EQ_CARRY_EN defined, the module SHALL add output carry_out, 1 bit, equal to bit WIDTH of the (WIDTH+1)-bit unsigned sum of in0 and in1, combinational.
REQ-027 Without ADD_BR_DUMMY_EQ_CARRY_EN, port carry_out SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 Package add_br_dummy_eq_pkg SHALL hold the default WIDTH (32) and STATE_W (32) constants and a data-word typedef of WIDTH bits.
REQ-029 The comparator SHALL be a parameterized sub-module named eq (in0, in1, out), instantiated once; the adder and branch mux are inline.

Verification
REQ-030 Reset: assert rst with en=1, in0=5, in1=7, br_false_target=2 -> add_reg=0, eq_reg=0, br_next=2 immediately; add_out=12.
REQ-031 Loop-counter: in0=3, in1=1, cmp_in1=4, en pulse -> add_out=4, eq_out=1; after edge add_reg=4, eq_reg=1, br_next=br_true_target (6).
REQ-032 Wrap: in0=0xFFFFFFFF, in1=1, cmp_in1=0 -> add_out=0, eq_out=1; carry_out=1 when ADD_BR_DUMMY_EQ_CARRY_EN is defined.
REQ-033 Hold: capture 0x10, then change in0/in1 with en=0 for 5 cycles -> add_reg stays 0x10, add_out tracks inputs.
REQ-034 Async reset mid-cycle: assert rst between edges after a capture of eq_reg=1 -> eq_reg=0 and br_next=br_false_target before the next edge.

Source files
------------

// File: rtl/add_br_dummy_eq_pkg.sv
// add_br_dummy_eq_pkg
//   Shared constants and types for the add/compare/branch slice.
//   DEFAULT_WIDTH   : default data operand width (bits)
//   DEFAULT_STATE_W : default branch-target (FSM state) width (bits)
//   data_word_t     : data word of DEFAULT_WIDTH bits
package add_br_dummy_eq_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_STATE_W = 32;

    typedef logic [DEFAULT_WIDTH-1:0] data_word_t;

endpackage

// File: rtl/add_br_dummy_eq_eq.sv
// eq
//   Parameterized unsigned bitwise equality comparator.
//   Ports:
//     in0 [WIDTH-1:0] : operand A
//     in1 [WIDTH-1:0] : operand B
//     out             : 1 iff every bit of in0 equals in1
module eq
    import add_br_dummy_eq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out
);

    always_comb begin
        out = (in0 == in1);
    end

endmodule

// File: rtl/add_br_dummy_eq.sv
// add_br_dummy_eq
//   Adder feeding an equality compare, with a capture register and a
//   branch-target mux driven from the registered compare result.
//   Optional feature macro: ADD_BR_DUMMY_EQ_CARRY_EN adds the carry_out port.
//   Ports:
//     clk             : clock, rising edge
//     rst             : asynchronous active-high reset
//     in0, in1        : adder operands (WIDTH)
//     cmp_in1         : comparison operand for the sum (WIDTH)
//     en              : capture strobe for add_reg / eq_reg
//     br_true_target  : next state when eq_reg is 1 (STATE_W)
//     br_false_target : next state when eq_reg is 0 (STATE_W)
//     add_out         : combinational sum, wraps modulo 2^WIDTH
//     eq_out          : combinational (add_out == cmp_in1)
//     add_reg         : registered sum
//     eq_reg          : registered compare
//     carry_out       : (macro only) bit WIDTH of the unsigned sum
//     br_next         : selected branch target
module add_br_dummy_eq
    import add_br_dummy_eq_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned STATE_W = DEFAULT_STATE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   cmp_in1,
    input  logic               en,
    input  logic [STATE_W-1:0] br_true_target,
    input  logic [STATE_W-1:0] br_false_target,
    output logic [WIDTH-1:0]   add_out,
    output logic               eq_out,
    output logic [WIDTH-1:0]   add_reg,
    output logic               eq_reg,
`ifdef ADD_BR_DUMMY_EQ_CARRY_EN
    output logic               carry_out,
`endif
    output logic [STATE_W-1:0] br_next
);

`ifdef ADD_BR_DUMMY_EQ_CARRY_EN
    // Widen by one bit so the carry falls out of the same adder.
    logic [WIDTH:0] sum_ext;

    always_comb begin
        sum_ext   = {1'b0, in0} + {1'b0, in1};
        add_out   = sum_ext[WIDTH-1:0];
        carry_out = sum_ext[WIDTH];
    end
`else
    always_comb begin
        add_out = in0 + in1;
    end
`endif

    eq #(
        .WIDTH (WIDTH)
    ) u_eq (
        .in0 (add_out),
        .in1 (cmp_in1),
        .out (eq_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_reg <= '0;
            eq_reg  <= 1'b0;
        end else if (en) begin
            add_reg <= add_out;
            eq_reg  <= eq_out;
        end
    end

    // Branch selection looks only at the captured compare, never eq_out.
    always_comb begin
        br_next = eq_reg ? br_true_target : br_false_target;
    end

endmodule

// File: tb/tb_add_br_dummy_eq.sv
// tb_add_br_dummy_eq
//   Directed self-checking bench for add_br_dummy_eq with a scoreboard
//   queue of expected captures.
module tb_add_br_dummy_eq;
    import add_br_dummy_eq_pkg::*;

    localparam int unsigned W  = DEFAULT_WIDTH;
    localparam int unsigned SW = DEFAULT_STATE_W;

    typedef struct {
        logic [W-1:0] add;
        logic         eqv;
    } cap_t;

    logic          clk;
    logic          rst;
    data_word_t    in0, in1, cmp_in1;
    logic          en;
    logic [SW-1:0] br_true_target, br_false_target;
    logic [W-1:0]  add_out, add_reg;
    logic          eq_out, eq_reg;
    logic [SW-1:0] br_next;
`ifdef ADD_BR_DUMMY_EQ_CARRY_EN
    logic          carry_out;
`endif

    int unsigned n_checks;
    int unsigned n_pass;
    cap_t        sb[$];

    add_br_dummy_eq #(
        .WIDTH   (W),
        .STATE_W (SW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in0             (in0),
        .in1             (in1),
        .cmp_in1         (cmp_in1),
        .en              (en),
        .br_true_target  (br_true_target),
        .br_false_target (br_false_target),
        .add_out         (add_out),
        .eq_out          (eq_out),
        .add_reg         (add_reg),
        .eq_reg          (eq_reg),
`ifdef ADD_BR_DUMMY_EQ_CARRY_EN
        .carry_out       (carry_out),
`endif
        .br_next         (br_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Combinational checks against a bench-side model of the inputs.
    task automatic check_comb(input string tag);
        logic [W:0] s;
        s = {1'b0, in0} + {1'b0, in1};
        check({tag, ".add_out"}, 64'(add_out), 64'(s[W-1:0]));
        check({tag, ".eq_out"}, 64'(eq_out), 64'(s[W-1:0] == cmp_in1));
`ifdef ADD_BR_DUMMY_EQ_CARRY_EN
        check({tag, ".carry_out"}, 64'(carry_out), 64'(s[W]));
`endif
    endtask

    task automatic push_expected();
        cap_t c;
        c.add = in0 + in1;
        c.eqv = ((in0 + in1) == cmp_in1);
        sb.push_back(c);
    endtask

    task automatic pop_check(input string tag);
        cap_t c;
        n_checks++;
        assert (sb.size() > 0) n_pass++;
        else $error("FAIL %s.sb_empty: observed 0 entries expected >=1", tag);
        if (sb.size() > 0) begin
            c = sb.pop_front();
            check({tag, ".add_reg"}, 64'(add_reg), 64'(c.add));
            check({tag, ".eq_reg"}, 64'(eq_reg), 64'(c.eqv));
            check({tag, ".br_next"}, 64'(br_next),
                  64'(c.eqv ? br_true_target : br_false_target));
        end
    endtask

    // Drive operands at the falling edge with en=1, capture at the rising edge.
    task automatic capture(input string tag, input data_word_t a, input data_word_t b,
                           input data_word_t c);
        @(negedge clk);
        in0 = a; in1 = b; cmp_in1 = c; en = 1'b1;
        #1;
        check_comb(tag);
        push_expected();
        @(posedge clk);
        #1;
        en = 1'b0;
        pop_check(tag);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        br_true_target  = SW'(6);
        br_false_target = SW'(2);
        rst = 1'b1; en = 1'b1;
        in0 = 32'd5; in1 = 32'd7; cmp_in1 = '0;

        // Reset state before any clock edge.
        #1;
        check("rst.add_reg", 64'(add_reg), 64'd0);
        check("rst.eq_reg", 64'(eq_reg), 64'd0);
        check("rst.br_next", 64'(br_next), 64'd2);
        check("rst.add_out", 64'(add_out), 64'd12);

        // Reset overrides en across a rising edge, with eq_out high.
        cmp_in1 = 32'd12;
        @(posedge clk); #1;
        check("rst_en.add_reg", 64'(add_reg), 64'd0);
        check("rst_en.eq_reg", 64'(eq_reg), 64'd0);
        check("rst_en.eq_out", 64'(eq_out), 64'd1);

        @(negedge clk);
        rst = 1'b0; en = 1'b0;

        // Loop-counter compare hits.
        capture("loop", 32'd3, 32'd1, 32'd4);
        check("loop.br_true", 64'(br_next), 64'd6);

        // Wrap-around to zero.
        capture("wrap", 32'hFFFF_FFFF, 32'd1, 32'd0);

        // Max + max, compare off by one.
        capture("maxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("maxmax.br_false", 64'(br_next), 64'd2);

        // Hold: capture 0x10 (not equal), then vary inputs with en=0.
        capture("hold_cap", 32'h8, 32'h8, 32'h11);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in0 = $urandom;
            in1 = $urandom;
            // Make eq_out high on alternate cycles to show eq_reg ignores it.
            cmp_in1 = (i % 2 == 0) ? (in0 + in1) : $urandom;
            #1;
            check_comb("hold");
            @(posedge clk); #1;
            check("hold.add_reg", 64'(add_reg), 64'h10);
            check("hold.eq_reg", 64'(eq_reg), 64'd0);
            check("hold.br_next", 64'(br_next), 64'd2);
        end

        // Async reset mid-cycle after capturing eq_reg=1.
        br_true_target  = SW'(32'hA5A5_0001);
        br_false_target = SW'(32'h0000_0077);
        capture("pre_arst", 32'd2, 32'd2, 32'd4);
        check("pre_arst.br_true", 64'(br_next), 64'hA5A5_0001);
        #2;
        rst = 1'b1;
        #1;
        check("arst.eq_reg", 64'(eq_reg), 64'd0);
        check("arst.add_reg", 64'(add_reg), 64'd0);
        check("arst.br_next", 64'(br_next), 64'h77);
        check_comb("arst");
        @(negedge clk);
        rst = 1'b0;

        // Normal capture resumes after reset release.
        capture("post", 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);

        n_checks++;
        assert (sb.size() == 0) n_pass++;
        else $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
